// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC handshake, single-outstanding imem
//            request, and a first-word-fall-through result FIFO with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_misalign,
  output logic              inst_buserr,
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] c_PTR_ONE = PW'(1);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MIS   = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [CW-1:0]     count_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic              mis_mem  [FIFO_DEPTH];
  logic              err_mem  [FIFO_DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              push_mis;
  logic              push_err;

  assign pc_ready = !rst && (state_q == S_IDLE) && !flush && (count_q < c_DEPTH);
  assign accept   = pc_valid && pc_ready;
  assign imem_req = !rst && (state_q == S_REQ);
  assign imem_addr = imem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign busy     = !rst && (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    push      = 1'b0;
    push_data = '0;
    push_mis  = 1'b0;
    push_err  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = pc_in;
          state_d = (pc_in[1:0] != 2'b00) ? S_MIS : S_REQ;
        end
      end
      S_MIS: begin
        push     = !flush;
        push_mis = 1'b1;
        state_d  = S_IDLE;
      end
      S_REQ: begin
        if (imem_gnt) state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // A flush in the same cycle as the response simply discards it.
          push      = !flush;
          push_err  = imem_err;
          push_data = imem_err ? '0 : imem_rdata;
          state_d   = S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) push = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + c_PTR_ONE;
      if (pop)  rptr_q <= rptr_q + c_PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + c_CNT_ONE;
        2'b01:   count_q <= count_q - c_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]   <= addr_q;
      data_mem[wptr_q] <= push_data;
      mis_mem[wptr_q]  <= push_mis;
      err_mem[wptr_q]  <= push_err;
    end
  end

  assign inst_pc       = inst_valid ? pc_mem[rptr_q]   : '0;
  assign inst_data     = inst_valid ? data_mem[rptr_q] : '0;
  assign inst_misalign = inst_valid ? mis_mem[rptr_q]  : 1'b0;
  assign inst_buserr   = inst_valid ? err_mem[rptr_q]  : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_misalign;
  logic        inst_buserr;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
    .inst_data(inst_data), .inst_misalign(inst_misalign), .inst_buserr(inst_buserr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] addr);
    pc_in = addr;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = data;
    imem_err = err;
    tick();
    imem_rvalid = 1'b0;
    imem_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_in = '0; pc_valid = 1'b1; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_imem_addr", imem_addr, 0);

    // 1: single fetch with earliest latency
    rst = 1'b0; pc_valid = 1'b0; inst_ready = 1'b1;
    pc_in = 32'h0; pc_valid = 1'b1;
    #1;
    chk("t1_pc_ready", pc_ready, 1);
    tick();
    pc_valid = 1'b0;
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_busy", busy, 1);
    chk("t1_pc_ready_busy", pc_ready, 0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("t1_req_after_gnt", imem_req, 0);
    chk("t1_valid_early", inst_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
    tick();
    imem_rvalid = 1'b0;
    chk("t1_valid", inst_valid, 1);
    chk("t1_pc", inst_pc, 32'h0);
    chk("t1_data", inst_data, 32'h00500093);
    chk("t1_mis", inst_misalign, 0);
    chk("t1_err", inst_buserr, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_popped", inst_valid, 0);

    // 2: back-pressure with a two-entry buffer
    inst_ready = 1'b0;
    accept(32'h0);
    respond(32'hAAAA0000, 1'b0);
    accept(32'h4);
    respond(32'hBBBB0004, 1'b0);
    pc_in = 32'h8; pc_valid = 1'b1;
    #1;
    chk("t2_full_ready", pc_ready, 0);
    tick();
    chk("t2_full_noreq", imem_req, 0);
    chk("t2_full_busy", busy, 0);
    chk("t2_head0_pc", inst_pc, 32'h0);
    chk("t2_head0_data", inst_data, 32'hAAAA0000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t2_ready_after_pop", pc_ready, 1);
    chk("t2_head1_pc", inst_pc, 32'h4);
    tick();
    pc_valid = 1'b0;
    chk("t2_req8", imem_req, 1);
    chk("t2_addr8", imem_addr, 32'h8);
    respond(32'hCCCC0008, 1'b0);
    chk("t2_head1_data", inst_data, 32'hBBBB0004);
    inst_ready = 1'b1;
    tick();
    chk("t2_head2_pc", inst_pc, 32'h8);
    chk("t2_head2_data", inst_data, 32'hCCCC0008);
    tick();
    inst_ready = 1'b0;
    chk("t2_empty", inst_valid, 0);

    // 3: misaligned address bypasses memory
    accept(32'h6);
    chk("t3_noreq", imem_req, 0);
    chk("t3_busy", busy, 1);
    chk("t3_not_yet", inst_valid, 0);
    tick();
    chk("t3_valid", inst_valid, 1);
    chk("t3_mis", inst_misalign, 1);
    chk("t3_data", inst_data, 0);
    chk("t3_pc", inst_pc, 32'h6);
    chk("t3_noreq2", imem_req, 0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t3_popped", inst_valid, 0);

    // 4: bus error
    accept(32'h10);
    respond(32'hFFFFFFFF, 1'b1);
    chk("t4_valid", inst_valid, 1);
    chk("t4_err", inst_buserr, 1);
    chk("t4_data", inst_data, 0);
    chk("t4_pc", inst_pc, 32'h10);
    chk("t4_mis", inst_misalign, 0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // 5: flush in WAIT with one buffered entry
    accept(32'h20);
    respond(32'h11111111, 1'b0);
    accept(32'h24);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("t5_buffered", inst_valid, 1);
    flush = 1'b1; pc_valid = 1'b1; pc_in = 32'h30;
    #1;
    chk("t5_flush_ready", pc_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("t5_cleared", inst_valid, 0);
    chk("t5_drain_busy", busy, 1);
    chk("t5_drain_ready", pc_ready, 0);
    tick();
    pc_valid = 1'b0;
    chk("t5_still_drain", busy, 1);
    imem_rvalid = 1'b1; imem_rdata = 32'h22222222;
    tick();
    imem_rvalid = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_discarded", inst_valid, 0);
    accept(32'h40);
    respond(32'h40404040, 1'b0);
    chk("t5_pc40", inst_pc, 32'h40);
    chk("t5_data40", inst_data, 32'h40404040);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t5_only40", inst_valid, 0);

    // 6: flush with gnt, flush without gnt, reset mid-REQ
    accept(32'h50);
    imem_gnt = 1'b1; flush = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b0;
    chk("t6_drain", busy, 1);
    chk("t6_drain_noreq", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h55555555;
    tick();
    imem_rvalid = 1'b0;
    chk("t6_drain_idle", busy, 0);
    chk("t6_drain_discard", inst_valid, 0);
    accept(32'h70);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_drop_idle", busy, 0);
    chk("t6_drop_noreq", imem_req, 0);
    accept(32'h60);
    chk("t6_req", imem_req, 1);
    rst = 1'b1; pc_valid = 1'b1;
    #1;
    chk("t6_rst_ready", pc_ready, 0);
    tick();
    rst = 1'b0; pc_valid = 1'b0;
    #1;
    chk("t6_rst_noreq", imem_req, 0);
    chk("t6_rst_valid", inst_valid, 0);
    chk("t6_rst_busy", busy, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("t6_stray_valid", inst_valid, 0);
    chk("t6_stray_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
